// File: rtl/seq_mult_unit_pkg.sv
// seq_mult_unit_pkg
//   Shared encodings and default sizes for the iterative shift-add multiplier.
//   mul_state_e : IDLE / CALC / DONE controller states (2-bit encoding)
//   MUL_WORD_LEN: default operand width
//   MUL_CNT_W   : default iteration counter width (2**MUL_CNT_W > MUL_WORD_LEN)
package seq_mult_unit_pkg;

   localparam int MUL_WORD_LEN = 32;
   localparam int MUL_CNT_W    = 6;

   typedef enum logic [1:0] {
      MUL_IDLE = 2'd0,
      MUL_CALC = 2'd1,
      MUL_DONE = 2'd2
   } mul_state_e;

endpackage

// File: rtl/seq_mult_unit.sv
// seq_mult_unit
//   Iterative radix-2 shift-add multiplier for the EXE stage. One multiplier bit
//   is consumed per clock; the 2*WORD_LEN product is written to hi/lo on the
//   edge that enters DONE. Stall freezes IF/ID while a multiply is in flight.
// Ports
//   clk_i        rising-edge clock
//   rst_ni       asynchronous reset, active low
//   start_i      multiply request (ignored while calculating)
//   is_signed_i  1 = two's-complement operands
//   flush_i      synchronous abort back to IDLE, beats start and completion
//   op_a_i       multiplicand
//   op_b_i       multiplier
//   busy_o       registered, high while calculating
//   stall_o      combinational freeze request
//   done_o       registered one-cycle result-valid pulse
//   hi_o, lo_o   product halves, held until the next completion
module seq_mult_unit
   import seq_mult_unit_pkg::*;
#(
   parameter int WORD_LEN = MUL_WORD_LEN,
   parameter int CNT_W    = MUL_CNT_W
) (
   input  logic                clk_i,
   input  logic                rst_ni,
   input  logic                start_i,
   input  logic                is_signed_i,
   input  logic                flush_i,
   input  logic [WORD_LEN-1:0] op_a_i,
   input  logic [WORD_LEN-1:0] op_b_i,
   output logic                busy_o,
   output logic                stall_o,
   output logic                done_o,
   output logic [WORD_LEN-1:0] hi_o,
   output logic [WORD_LEN-1:0] lo_o
);

   mul_state_e            state_q;
   logic [WORD_LEN-1:0]   mcand_q, mplier_q, acc_q;
   logic                  neg_q;
   logic [CNT_W-1:0]      cnt_q;
   logic                  busy_q, done_q;
   logic [WORD_LEN-1:0]   hi_q, lo_q;

   logic [WORD_LEN:0]     sum;
   logic [WORD_LEN-1:0]   acc_d, mplier_d;
   logic [2*WORD_LEN-1:0] prod, res;
   logic [WORD_LEN-1:0]   mag_a, mag_b;
   logic                  neg_d, last;

   // One shift-add step. The carry out of the add becomes the new acc MSB,
   // and the bit shifted out of acc becomes the new mplier MSB, so the low
   // product bits accumulate in the multiplier register as it drains.
   always_comb begin
      sum      = {1'b0, acc_q} + (mplier_q[0] ? {1'b0, mcand_q} : '0);
      acc_d    = sum[WORD_LEN:1];
      mplier_d = {sum[0], mplier_q[WORD_LEN-1:1]};
      prod     = {acc_d, mplier_d};
      res      = neg_q ? -prod : prod;
      last     = (cnt_q == CNT_W'(WORD_LEN-1));
   end

   // Magnitudes stay WORD_LEN-bit unsigned: |-2**(W-1)| = 2**(W-1) still fits.
   always_comb begin
      mag_a = (is_signed_i & op_a_i[WORD_LEN-1]) ? -op_a_i : op_a_i;
      mag_b = (is_signed_i & op_b_i[WORD_LEN-1]) ? -op_b_i : op_b_i;
      neg_d = is_signed_i & (op_a_i[WORD_LEN-1] ^ op_b_i[WORD_LEN-1]);
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q  <= MUL_IDLE;
         mcand_q  <= '0;
         mplier_q <= '0;
         acc_q    <= '0;
         neg_q    <= 1'b0;
         cnt_q    <= '0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         hi_q     <= '0;
         lo_q     <= '0;
      end else if (flush_i) begin
         state_q <= MUL_IDLE;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         case (state_q)
            MUL_CALC: begin
               acc_q    <= acc_d;
               mplier_q <= mplier_d;
               cnt_q    <= cnt_q + CNT_W'(1);
               if (last) begin
                  {hi_q, lo_q} <= res;
                  state_q      <= MUL_DONE;
                  busy_q       <= 1'b0;
                  done_q       <= 1'b1;
               end
            end
            default: begin
               // IDLE and DONE both accept a new request.
               done_q <= 1'b0;
               if (start_i) begin
                  mcand_q  <= mag_a;
                  mplier_q <= mag_b;
                  neg_q    <= neg_d;
                  acc_q    <= '0;
                  cnt_q    <= '0;
                  state_q  <= MUL_CALC;
                  busy_q   <= 1'b1;
               end else begin
                  state_q <= MUL_IDLE;
                  busy_q  <= 1'b0;
               end
            end
         endcase
      end
   end

   // Raised in the accept cycle too, so the pipeline cannot advance past it.
   assign stall_o = (start_i & (state_q != MUL_CALC)) | (state_q == MUL_CALC);
   assign busy_o  = busy_q;
   assign done_o  = done_q;
   assign hi_o    = hi_q;
   assign lo_o    = lo_q;

endmodule

// File: tb/tb_seq_mult_unit.sv
module tb_seq_mult_unit;

   localparam int W = 32;

   logic          clk = 1'b0;
   logic          rst_n = 1'b1;
   logic          start = 1'b0, is_signed = 1'b0, flush = 1'b0;
   logic [W-1:0]  op_a = '0, op_b = '0;
   logic          busy, stall, done;
   logic [W-1:0]  hi, lo;

   int checks = 0;
   int failures = 0;
   bit chk_en = 1'b0;

   seq_mult_unit dut (
      .clk_i(clk), .rst_ni(rst_n), .start_i(start), .is_signed_i(is_signed),
      .flush_i(flush), .op_a_i(op_a), .op_b_i(op_b), .busy_o(busy),
      .stall_o(stall), .done_o(done), .hi_o(hi), .lo_o(lo)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h expected=%h @%0t", nm, act, exp, $time);
      end
   endtask

   // Behavioural model: an accepted request yields the full-width arithmetic
   // product exactly W clocks later; nothing else disturbs the result.
   int          m_left = 0;
   logic        m_done = 1'b0;
   logic [63:0] m_pend = '0, m_res = '0;

   function automatic logic [63:0] ref_prod(logic [W-1:0] a, logic [W-1:0] b, logic s);
      longint sa, sb;
      if (s) begin
         sa = longint'($signed(a));
         sb = longint'($signed(b));
         return 64'(sa * sb);
      end
      return {32'b0, a} * {32'b0, b};
   endfunction

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_left = 0; m_done = 1'b0; m_res = '0;
      end else if (flush) begin
         m_left = 0; m_done = 1'b0;
      end else if (m_left > 0) begin
         m_left--;
         m_done = (m_left == 0);
         if (m_left == 0) m_res = m_pend;
      end else begin
         m_done = 1'b0;
         if (start) begin
            m_pend = ref_prod(op_a, op_b, is_signed);
            m_left = W;
         end
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         chk("model_busy", 64'(busy), 64'(m_left > 0));
         chk("model_done", 64'(done), 64'(m_done));
         chk("model_stall", 64'(stall), 64'((start && m_left == 0) || m_left > 0));
         chk("model_hilo", {hi, lo}, m_res);
      end
   end

   // Wait for done, counting clock edges since the accept edge.
   task automatic wait_done(output int n);
      n = 0;
      do begin
         @(posedge clk); n++; #1;
      end while (!done && n < 100);
      if (!done) chk("done_timeout", 64'(n), 64'(W));
   endtask

   // Request on a negedge; start is released 1 time unit after the accept edge.
   task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
      @(negedge clk);
      op_a = a; op_b = b; is_signed = s; start = 1'b1;
      #1 chk("stall_accept", 64'(stall), 64'd1);
      @(posedge clk); #1 start = 1'b0;
   endtask

   task automatic run_mul(input string nm, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic s, input logic [W-1:0] ehi, input logic [W-1:0] elo);
      int n;
      issue(a, b, s);
      wait_done(n);
      chk({nm, "_lat"}, 64'(n), 64'(W));
      chk({nm, "_hi"}, 64'(hi), 64'(ehi));
      chk({nm, "_lo"}, 64'(lo), 64'(elo));
      chk({nm, "_stall_done"}, 64'(stall), 64'd0);
      @(posedge clk); #1 chk({nm, "_done_pulse"}, 64'(done), 64'd0);
   endtask

   initial begin
      int n;
      bit seen;
      #2 rst_n = 1'b0;
      #1 chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_done", 64'(done), 64'd0);
      chk("rst_hilo", {hi, lo}, 64'd0);
      @(posedge clk); #1 rst_n = 1'b1;
      chk_en = 1'b1;

      run_mul("u6x7", 32'd6, 32'd7, 1'b0, 32'h0, 32'h2A);
      run_mul("s_m3x5", 32'hFFFFFFFD, 32'h5, 1'b1, 32'hFFFFFFFF, 32'hFFFFFFF1);
      run_mul("u_max2", 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 32'hFFFFFFFE, 32'h1);
      run_mul("s_m1m1", 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 32'h0, 32'h1);

      // Most-negative squared, with a 9*9 request arriving mid-calculation.
      issue(32'h80000000, 32'h80000000, 1'b1);
      repeat (5) @(posedge clk);
      #1 op_a = 32'd9; op_b = 32'd9; is_signed = 1'b0; start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
      wait_done(n);
      chk("s_minmin_lat", 64'(n), 64'(W - 6));
      chk("s_minmin_hi", 64'(hi), 64'h40000000);
      chk("s_minmin_lo", 64'(lo), 64'h0);
      @(posedge clk); #1 chk("ignored_no_second", 64'(busy), 64'd0);

      // Flush mid-calculation keeps the prior result and never pulses done.
      run_mul("pre_flush", 32'd6, 32'd7, 1'b0, 32'h0, 32'h2A);
      issue(32'h12345678, 32'h9, 1'b0);
      repeat (10) @(posedge clk);
      #1 flush = 1'b1;
      @(posedge clk); #1 flush = 1'b0;
      chk("flush_busy", 64'(busy), 64'd0);
      seen = 1'b0;
      repeat (40) begin
         @(posedge clk); #1 if (done) seen = 1'b1;
      end
      chk("flush_no_done", 64'(seen), 64'd0);
      chk("flush_hilo_kept", {hi, lo}, 64'h2A);

      // Asynchronous reset mid-calculation.
      issue(32'd100, 32'd3, 1'b0);
      repeat (5) @(posedge clk);
      #2 rst_n = 1'b0;
      #1 chk("arst_busy", 64'(busy), 64'd0);
      chk("arst_done", 64'(done), 64'd0);
      chk("arst_hilo", {hi, lo}, 64'd0);
      @(posedge clk); #1 rst_n = 1'b1;

      // Back-to-back: second request held during the first DONE cycle.
      issue(32'd6, 32'd7, 1'b0);
      wait_done(n);
      chk("b2b_first_lo", 64'(lo), 64'h2A);
      op_a = 32'd2; op_b = 32'd3; is_signed = 1'b0; start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
      chk("b2b_busy", 64'(busy), 64'd1);
      wait_done(n);
      chk("b2b_lat", 64'(n), 64'(W));
      chk("b2b_hi", 64'(hi), 64'h0);
      chk("b2b_lo", 64'(lo), 64'h6);

      repeat (3) @(posedge clk);
      chk_en = 1'b0;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
